edf_ic_dyn: RTL

- Earliest-deadline-first interrupt controller with dynamic deadlines.
- Each line has a software-programmed relative deadline. When the line pends, the block latches an absolute deadline: the low TsWidth bits of mtime plus the relative deadline.
- Arbitration uses a wrap-safe comparison. The winner is registered.
- Optional sticky deadline-miss detection.
- Sits between the external interrupt sources and the core's interrupt/claim interface. Configured over the cfg bus.

---
 rtl/edf_ic_pkg.sv | 32 +++
 rtl/edf_ic_gateway.sv | 30 +++
 rtl/edf_ic_dyn.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/edf_ic_pkg.sv
// rtl/edf_ic_pkg.sv - shared types, register map and wrap-safe compare for edf_ic_dyn
package edf_ic_pkg;

  localparam int CtrlIe   = 0;
  localparam int CtrlIp   = 1;
  localparam int CtrlTrig = 2;
  localparam int CtrlPol  = 3;
  localparam int CtrlMiss = 4;

  localparam logic [1:0] RegCtrl = 2'd0;
  localparam logic [1:0] RegRel  = 2'd1;
  localparam logic [1:0] RegAbs  = 2'd2;

  // rel/abs are held at full 32-bit width and masked to RelWidth/TsWidth on write
  typedef struct packed {
    logic        ip;
    logic        ie;
    logic        trig_type;
    logic        trig_pol;
    logic        miss;
    logic [31:0] rel;
    logic [31:0] abs;
  } line_t;

  // a is earlier than b when (a - b), viewed as a signed w-bit value, is negative
  function automatic logic ts_before(logic [31:0] a, logic [31:0] b, int unsigned w);
    logic [31:0] d;
    d = (a - b) << (32 - w);
    return d[31];
  endfunction

endpackage

// File: rtl/edf_ic_gateway.sv
// rtl/edf_ic_gateway.sv - per-line level/edge detection producing request pulses
module edf_ic_gateway #(
  parameter int NrIrqs = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NrIrqs-1:0] irq_i,
  input  logic [NrIrqs-1:0] trig_type,
  input  logic [NrIrqs-1:0] trig_pol,
  output logic [NrIrqs-1:0] req
);

  logic [NrIrqs-1:0] irq_q;
  logic [NrIrqs-1:0] cur_act;
  logic [NrIrqs-1:0] prev_act;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q <= '0;
    end else begin
      irq_q <= irq_i;
    end
  end

  // normalise to "active" sense so one edge equation serves both polarities
  assign cur_act  = irq_i ^ trig_pol;
  assign prev_act = irq_q ^ trig_pol;
  assign req      = (trig_type & cur_act & ~prev_act) | (~trig_type & cur_act);

endmodule

// File: rtl/edf_ic_dyn.sv
// rtl/edf_ic_dyn.sv - EDF interrupt controller with dynamic deadlines; EDF_IC_DL_MISS_EN adds miss detection
module edf_ic_dyn
  import edf_ic_pkg::*;
#(
  parameter int          NrIrqs   = 8,
  parameter int          TsWidth  = 24,
  parameter int          RelWidth = 16,
  parameter logic [31:0] BaseAddr = 32'h0,
  localparam int         IdWidth  = $clog2(NrIrqs)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cfg_req_i,
  input  logic               cfg_we_i,
  input  logic [31:0]        cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o,
  input  logic [63:0]        mtime_i,
  input  logic [NrIrqs-1:0]  irq_i,
  output logic               irq_valid_o,
  output logic [IdWidth-1:0] irq_id_o,
  output logic [TsWidth-1:0] irq_dl_o,
  input  logic               irq_ack_i,
  input  logic [IdWidth-1:0] irq_id_i,
  output logic               miss_o
);

  localparam logic [31:0] TsMask  = (TsWidth == 32) ? 32'hFFFF_FFFF : ((32'd1 << TsWidth) - 32'd1);
  localparam logic [31:0] RelMask = (RelWidth == 32) ? 32'hFFFF_FFFF : ((32'd1 << RelWidth) - 32'd1);

  line_t line_q [NrIrqs];

  logic [31:0]        mtime_lo;
  logic [31:0]        off;
  logic               hit;
  logic [IdWidth-1:0] sel;
  logic [1:0]         rsel;
  logic               unused_bits;

  logic [NrIrqs-1:0] trig_type;
  logic [NrIrqs-1:0] trig_pol;
  logic [NrIrqs-1:0] gw_req;
  logic [NrIrqs-1:0] wr_ctrl;
  logic [NrIrqs-1:0] wr_rel;
  logic [NrIrqs-1:0] ack_hit;
  logic [NrIrqs-1:0] pend;
  logic [NrIrqs-1:0] late;
  logic [NrIrqs-1:0] miss_en;
  logic [31:0]       latch_abs [NrIrqs];

  logic               best_valid;
  logic [IdWidth-1:0] best_id;
  logic [31:0]        best_abs;

  assign mtime_lo    = mtime_i[31:0] & TsMask;
  assign off         = cfg_addr_i - BaseAddr;
  assign hit         = off < 32'(16 * NrIrqs);
  assign sel         = off[4 +: IdWidth];
  assign rsel        = off[3:2];
  assign unused_bits = ^{mtime_i[63:32], off[1:0]};

  edf_ic_gateway #(.NrIrqs(NrIrqs)) u_gateway (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .irq_i     (irq_i),
    .trig_type (trig_type),
    .trig_pol  (trig_pol),
    .req       (gw_req)
  );

  always_comb begin
    for (int i = 0; i < NrIrqs; i++) begin
      trig_type[i] = line_q[i].trig_type;
      trig_pol[i]  = line_q[i].trig_pol;
      miss_en[i]   = line_q[i].miss & line_q[i].ie;
      wr_ctrl[i]   = cfg_req_i && cfg_we_i && hit && (sel == IdWidth'(i)) && (rsel == RegCtrl);
      wr_rel[i]    = cfg_req_i && cfg_we_i && hit && (sel == IdWidth'(i)) && (rsel == RegRel);
      ack_hit[i]   = irq_ack_i && (irq_id_i == IdWidth'(i)) && line_q[i].ip;
      // a held request re-pends only when the same cycle's claim frees the line
      pend[i]      = (gw_req[i] && (!line_q[i].ip || ack_hit[i])) ||
                     (wr_ctrl[i] && cfg_wdata_i[CtrlIp] && !line_q[i].ip);
      latch_abs[i] = (mtime_lo + line_q[i].rel) & TsMask;
    end
  end

`ifdef EDF_IC_DL_MISS_EN
  always_comb begin
    logic [31:0] d;
    for (int i = 0; i < NrIrqs; i++) begin
      d       = (mtime_lo - line_q[i].abs) << (32 - TsWidth);
      late[i] = line_q[i].ip && !d[31] && (d != 32'd0);
    end
  end
`else
  assign late = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q <= '{default: '0};
    end else begin
      for (int i = 0; i < NrIrqs; i++) begin
        if (wr_ctrl[i]) begin
          line_q[i].ie        <= cfg_wdata_i[CtrlIe];
          line_q[i].trig_type <= cfg_wdata_i[CtrlTrig];
          line_q[i].trig_pol  <= cfg_wdata_i[CtrlPol];
        end
        if (wr_rel[i]) begin
          line_q[i].rel <= cfg_wdata_i & RelMask;
        end
        if (pend[i]) begin
          line_q[i].ip  <= 1'b1;
          line_q[i].abs <= latch_abs[i];
        end else if (ack_hit[i]) begin
          line_q[i].ip <= 1'b0;
        end else if (wr_ctrl[i]) begin
          line_q[i].ip <= cfg_wdata_i[CtrlIp];
        end
`ifdef EDF_IC_DL_MISS_EN
        line_q[i].miss <= late[i] | (line_q[i].miss & ~(wr_ctrl[i] & cfg_wdata_i[CtrlMiss]));
`else
        line_q[i].miss <= 1'b0;
`endif
      end
    end
  end

  // strict "before" keeps the lower index on equal deadlines
  always_comb begin
    best_valid = 1'b0;
    best_id    = '0;
    best_abs   = '0;
    for (int i = 0; i < NrIrqs; i++) begin
      if (line_q[i].ip && line_q[i].ie &&
          (!best_valid || ts_before(line_q[i].abs, best_abs, TsWidth))) begin
        best_valid = 1'b1;
        best_id    = IdWidth'(i);
        best_abs   = line_q[i].abs;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_valid_o <= 1'b0;
      irq_id_o    <= '0;
      irq_dl_o    <= '0;
      miss_o      <= 1'b0;
    end else begin
      irq_valid_o <= best_valid;
      if (best_valid) begin
        irq_id_o <= best_id;
        irq_dl_o <= best_abs[TsWidth-1:0];
      end
      miss_o <= |miss_en;
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    if (cfg_req_i && !cfg_we_i && hit) begin
      case (rsel)
        RegCtrl: cfg_rdata_o = {27'd0, line_q[sel].miss, line_q[sel].trig_pol,
                                line_q[sel].trig_type, line_q[sel].ip, line_q[sel].ie};
        RegRel:  cfg_rdata_o = line_q[sel].rel;
        RegAbs:  cfg_rdata_o = line_q[sel].abs;
        default: cfg_rdata_o = '0;
      endcase
    end
  end

endmodule
